// File: rtl/bcd_convert_unit_if.sv
// ---------------------------------------------------------------------------
// bcd_convert_unit_if
//   Bus bundle for the binary/BCD converter.
//
//   Handshake: the master raises start (with op and the operand) and holds the
//   operand stable for the edge on which the unit is IDLE and rdy=1; that edge
//   accepts the request. busy is high from the next cycle through the done
//   cycle. done is a one-cycle (one enabled cycle) pulse qualifying bin_o,
//   bcd_o, ovf and err, which then stay stable until the next accepted start.
//   start is ignored whenever busy=1.
//
//   Signals
//     start      master->slave  request a conversion
//     op         master->slave  0 = binary->BCD, 1 = BCD->binary
//     bin_i      master->slave  binary operand (op=0)
//     bcd_i      master->slave  packed BCD operand (op=1), digit 0 in [3:0]
//     busy       slave->master  conversion in progress (including done cycle)
//     done       slave->master  result strobe
//     bin_o      slave->master  binary result (op=1)
//     bcd_o      slave->master  BCD result (op=0)
//     ovf        slave->master  op=1: BCD value does not fit in DBW bits
//     err        slave->master  op=1: an input digit was above 9
//     state_dbg  slave->master  FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
interface bcd_convert_unit_if #(
  parameter int DBW = 8,
  parameter int ND  = 3
);
  logic            start;
  logic            op;
  logic [DBW-1:0]  bin_i;
  logic [4*ND-1:0] bcd_i;
  logic            busy;
  logic            done;
  logic [DBW-1:0]  bin_o;
  logic [4*ND-1:0] bcd_o;
  logic            ovf;
  logic            err;
  logic [1:0]      state_dbg;

  modport master (
    output start, op, bin_i, bcd_i,
    input  busy, done, bin_o, bcd_o, ovf, err, state_dbg
  );

  modport slave (
    input  start, op, bin_i, bcd_i,
    output busy, done, bin_o, bcd_o, ovf, err, state_dbg
  );
endinterface

// File: rtl/bcd_convert_unit.sv
// ---------------------------------------------------------------------------
// bcd_convert_unit
//   Multi-cycle binary <-> packed BCD converter, one iteration per enabled
//   clock.
//     op=0: double dabble (digits >= 5 get +3, then shift left), DBW steps.
//     op=1: reverse double dabble (shift right, then digits >= 8 get -3),
//           4*ND steps.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset, wins over rdy
//     rdy    clock enable; 0 freezes every register, including a pending done
//     bus    bcd_convert_unit_if.slave (start/op/bin_i/bcd_i in,
//            busy/done/bin_o/bcd_o/ovf/err/state_dbg out)
//
//   Parameters
//     DBW  binary width
//     ND   BCD digit count; 10^ND must be >= 2^DBW so op=0 is always exact
// ---------------------------------------------------------------------------
module bcd_convert_unit #(
  parameter int DBW = 8,
  parameter int ND  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  bcd_convert_unit_if.slave bus
);

  localparam int BCW = 4 * ND;                    // BCD field width
  localparam int BW  = (DBW > BCW) ? DBW : BCW;   // binary field width
  localparam int WW  = BCW + BW;                  // working register width
  localparam int CW  = $clog2(BW + 1);            // iteration counter width

  localparam logic [CW-1:0] N_B2D = CW'(DBW);
  localparam logic [CW-1:0] N_D2B = CW'(BCW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  // Working register: BCD field in the top BCW bits, binary field below it.
  // The binary field is BW wide so that op=1 can convert the full BCD value
  // (up to 10^ND-1) before overflow is judged.
  logic [WW-1:0]   work;
  logic [WW-1:0]   work_nxt;
  logic [WW-1:0]   work_ld;
  logic [CW-1:0]   cnt;
  logic            op_q;
  logic            err_q;
  logic            digit_bad;
  logic [BW-1:0]   bin_field;

  logic [DBW-1:0]  bin_q;
  logic [BCW-1:0]  bcd_q;
  logic            ovf_q;
  logic            err_o_q;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic (only consulted on enabled edges)
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      // Counter at zero means all N iterations are done; this edge
      // registers the results.
      RUN:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.state_dbg = state;
  end

  assign bus.bin_o = bin_q;
  assign bus.bcd_o = bcd_q;
  assign bus.ovf   = ovf_q;
  assign bus.err   = err_o_q;

  // -------------------------------------------------------------------------
  // Operand checks and load image
  // -------------------------------------------------------------------------
  always_comb begin
    digit_bad = 1'b0;
    for (int d = 0; d < ND; d++) begin
      if (bus.bcd_i[4*d +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // op=0 puts the binary operand at the top of the binary field so that its
  // MSB is the first bit shifted into the BCD field.
  always_comb begin
    work_ld = '0;
    if (bus.op) begin
      work_ld[WW-1 -: BCW] = bus.bcd_i;
    end else begin
      work_ld[BW-1 -: DBW] = bus.bin_i;
    end
  end

  // -------------------------------------------------------------------------
  // One conversion iteration
  // -------------------------------------------------------------------------
  always_comb begin
    work_nxt = work;
    if (!op_q) begin
      for (int d = 0; d < ND; d++) begin
        if (work_nxt[BW + 4*d +: 4] >= 4'd5) begin
          work_nxt[BW + 4*d +: 4] = work_nxt[BW + 4*d +: 4] + 4'd3;
        end
      end
      work_nxt = work_nxt << 1;
    end else begin
      work_nxt = work_nxt >> 1;
      for (int d = 0; d < ND; d++) begin
        if (work_nxt[BW + 4*d +: 4] >= 4'd8) begin
          work_nxt[BW + 4*d +: 4] = work_nxt[BW + 4*d +: 4] - 4'd3;
        end
      end
    end
  end

  assign bin_field = work[BW-1:0];

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work    <= '0;
      cnt     <= '0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      err_o_q <= 1'b0;
    end else if (rdy) begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            work  <= work_ld;
            err_q <= bus.op & digit_bad;
            cnt   <= bus.op ? N_D2B : N_B2D;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            work <= work_nxt;
            cnt  <= cnt - CW'(1);
          end else if (!op_q) begin
            // Binary -> BCD: always exact; bin_o keeps its old value.
            bcd_q   <= work[WW-1 -: BCW];
            ovf_q   <= 1'b0;
            err_o_q <= 1'b0;
          end else begin
            // BCD -> binary: bcd_o keeps its old value. A bad digit forces
            // a zero result and suppresses overflow.
            err_o_q <= err_q;
            if (err_q) begin
              bin_q <= '0;
              ovf_q <= 1'b0;
            end else begin
              bin_q <= bin_field[DBW-1:0];
              ovf_q <= ((bin_field >> DBW) != '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
